// File: rtl/wormhole_out_arbiter.sv
// Output-port arbiter for one switch output: round-robin grant on header flits,
// wormhole lock held until the tail flit passes, feeding one registered output stage.
module wormhole_out_arbiter #(
    parameter int NUM_IN     = 5,
    parameter int WORD_WIDTH = 32,
    parameter int IDW        = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_IN*WORD_WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]            in_void,
    output logic [NUM_IN-1:0]            in_stop,
    output logic [WORD_WIDTH-1:0]        out_data,
    output logic                         out_void,
    input  logic                         out_stop,
    output logic [IDW-1:0]               grant_id,
    output logic                         busy,
    output logic [15:0]                  pkt_count,
    output logic                         protocol_err
);

    typedef enum logic {IDLE, LOCKED} state_t;

    localparam logic [1:0] TYPE_HDR = 2'b10;

    state_t                  state, state_nxt;
    logic [IDW-1:0]          rr_ptr;
    logic [IDW-1:0]          pick;
    logic [IDW-1:0]          idx;
    logic                    found;
    logic                    hdr_taken;
    logic                    load_ok;
    logic                    xfer;
    logic                    gnt_void;
    logic [WORD_WIDTH-1:0]   gnt_word;
    logic [1:0]              gnt_type;
    logic                    is_hdr;
    logic                    is_tail;
    logic [NUM_IN-1:0]       cand;

    function automatic logic [1:0] flit_type(input logic [WORD_WIDTH-1:0] w);
        return w[31:30];
    endfunction

    assign load_ok  = out_void | ~out_stop;
    assign busy     = (state == LOCKED);
    assign gnt_type = flit_type(gnt_word);
    assign is_hdr   = (gnt_type == TYPE_HDR);
    assign is_tail  = gnt_type[0];
    assign xfer     = busy & load_ok & ~gnt_void;

    // Word and void flag of the input currently holding the lock.
    always_comb begin
        gnt_word = '0;
        gnt_void = 1'b1;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_id == IDW'(i)) begin
                gnt_word = in_data[i*WORD_WIDTH +: WORD_WIDTH];
                gnt_void = in_void[i];
            end
        end
    end

    always_comb begin
        cand    = '0;
        in_stop = '1;
        for (int i = 0; i < NUM_IN; i++) begin
            cand[i]    = ~in_void[i] & (flit_type(in_data[i*WORD_WIDTH +: WORD_WIDTH]) == TYPE_HDR);
            in_stop[i] = reset | ~(busy & (grant_id == IDW'(i)) & load_ok);
        end
    end

    // Search starts just after the last winner, so it gets lowest priority.
    always_comb begin
        found = 1'b0;
        pick  = grant_id;
        idx   = '0;
        for (int k = 1; k <= NUM_IN; k++) begin
            idx = IDW'((int'(rr_ptr) + k) % NUM_IN);
            if (!found && cand[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = LOCKED;
            LOCKED:  if (xfer && is_tail) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr       <= IDW'(NUM_IN - 1);
            grant_id     <= '0;
            hdr_taken    <= 1'b0;
            pkt_count    <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (state == IDLE && found) begin
                grant_id  <= pick;
                hdr_taken <= 1'b0;
            end
            if (xfer) begin
                if (is_hdr) hdr_taken <= 1'b1;
                // A second header inside a locked packet is flagged but still forwarded.
                if (is_hdr && hdr_taken) protocol_err <= 1'b1;
                if (is_tail) begin
                    pkt_count <= pkt_count + 16'd1;
                    rr_ptr    <= grant_id;
                end
            end
        end
    end

    // Output register stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data <= '0;
            out_void <= 1'b1;
        end else if (xfer) begin
            out_data <= gnt_word;
            out_void <= 1'b0;
        end else if (load_ok) begin
            out_void <= 1'b1;
        end
    end

endmodule
